// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Receives a framed byte stream (length, 4*N little-endian data bytes, XOR
// checksum), writes one 32-bit word per cycle into the instruction memory and
// releases the core from reset only after a load with a matching checksum.
module imem_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [31:0]         word_q, word_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                xfer;
    logic [31:0]         word_next;

    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // State and datapath registers; async active-low reset clears everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            widx_q    <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            word_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            widx_q    <= widx_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            word_q    <= word_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state and output decode for the load sequence.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        widx_d    = widx_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        word_d    = word_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        core_hold = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        xfer      = 1'b0;
        word_next = {in_data, word_q[31:8]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN;
                    widx_d  = '0;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LEN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    len_d   = in_data[ADDR_W-1:0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    word_d = word_next;
                    csum_d = csum_q ^ in_data;
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        wr_addr_d = widx_q;
                        wr_data_d = word_next;
                        state_d   = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                busy  = 1'b1;
                wr_en = 1'b1;
                // len_q - 1 wraps to all-ones for N=0, giving the full-depth load.
                if (widx_q == (len_q - IDX_ONE)) begin
                    state_d = S_CSUM;
                end else begin
                    widx_d  = widx_q + IDX_ONE;
                    state_d = S_DATA;
                end
            end
            S_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
                if (start) begin
                    state_d = S_LEN;
                    widx_d  = '0;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    state_d = S_LEN;
                    widx_d  = '0;
                    csum_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives a synchronous write port into a writable instruction memory, one word per write, word-addressed from 0.
- Holds the core in reset (core_hold) until a load completes with a correct checksum.
- Sits between the external boot byte source (UART/test bench) and the instruction memory write port.

Parameters:
- ADDR_W, 6, word-address width; memory depth is 2**ADDR_W words (64).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  byte source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  word address of the write.
- wr_data  output  32  instruction word to write.
- core_hold  output  1  1 = core held in reset.
- busy  output  1  load in progress.
- done  output  1  last load succeeded.
- err  output  1  last load failed its checksum.

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=1, busy=0, done=0, err=0. Byte counter, word index, length and checksum registers are cleared.
- A byte transfers only on a rising edge where in_valid=1 and in_ready=1.
- in_ready=1 only in LEN, DATA and CSUM; it is 0 in every other state.
- Frame format: one length byte N, then 4*N data bytes, then one checksum byte.
  - N=0 means 2**ADDR_W words; N values above 2**ADDR_W do not occur for ADDR_W=6.
  - Each word's bytes arrive LSB first: byte0 goes to [7:0], byte3 goes to [31:24].
  - Checksum = XOR of all 4*N data bytes; the length byte is excluded.
- IDLE: waits for start, then goes to LEN with busy=1, core_hold=1, done=0, err=0, word index=0, checksum=0.
- LEN: on transfer, latches N and goes to DATA.
- DATA:
  - On each transfer, shifts the byte into the word assembly register, XORs it into the checksum and increments the 2-bit byte counter.
  - On the 4th byte, goes to WRITE.
- WRITE (exactly one cycle): wr_en=1, wr_addr=word index, wr_data=assembled word.
  - If word index == N-1 (mod 2**ADDR_W), goes to CSUM.
  - Otherwise increments the word index and returns to DATA.
  - Latency: wr_en asserts in the cycle after the transfer of a word's 4th byte.
- CSUM: on transfer, compares the received byte with the checksum register.
  - Match: goes to DONE.
  - Mismatch: goes to ERR.
- DONE: done=1, busy=0, core_hold=0. Holds until start.
- ERR: err=1, busy=0, core_hold=1. Holds until start.
- start in DONE or ERR restarts the load exactly as from IDLE; core_hold reasserts in the same edge.
- start while busy is ignored; the load in progress continues.
- wr_en is 1 only in WRITE. wr_addr and wr_data hold their last values when wr_en=0.
- Word index wraps naturally at 2**ADDR_W. The full-depth load (N=0) writes addresses 0..63 and ends with wr_addr=63.
- in_valid may stay high across WRITE; that byte is not consumed until in_ready returns.
- Reset during a load: returns immediately to IDLE. The partial word is discarded, wr_en drops in the same instant, and memory contents already written are untouched.

Test Plan:
- Reset, start, bytes 02, 03 23 00 00, 83 23 40 00, C0 -> write (0, 0x00002303), then write (1, 0x00402383); done=1, core_hold=0, err=0.
- Same frame with checksum byte C1 -> same two writes; then err=1, done=0, core_hold=1.
- Load of N=1 with in_valid toggling every other cycle -> exactly 4 data transfers, one wr_en pulse at address 0, in_ready=0 during the WRITE cycle, no byte lost or duplicated.
- N=0 with 256 data bytes, where word k = {k,k,k,k} -> 64 writes with wr_addr 0..63 in order; checksum 0x00 gives done=1.
- Pulse rst low after 6 data bytes of an N=2 load -> immediate IDLE, core_hold=1, no wr_en. A fresh start then completes a clean load from address 0.
- start pulsed mid-DATA -> ignored; load completes normally. start in DONE -> busy=1, core_hold=1, done=0 on the next cycle.
